// File: rtl/branch_ctrl_pkg.sv
// Shared ISA definitions for the branch sequencer: condition encodings,
// CCR bit positions and the branch FSM state encoding.
package branch_ctrl_pkg;

    // Branch condition field encodings (instr[25:22])
    localparam logic [3:0] BC_AL = 4'd0;
    localparam logic [3:0] BC_EQ = 4'd1;
    localparam logic [3:0] BC_NE = 4'd2;
    localparam logic [3:0] BC_LT = 4'd3;
    localparam logic [3:0] BC_LE = 4'd4;
    localparam logic [3:0] BC_GT = 4'd5;
    localparam logic [3:0] BC_GE = 4'd6;
    localparam logic [3:0] BC_CS = 4'd7;
    localparam logic [3:0] BC_CC = 4'd8;

    // Bit positions inside the CCR {N,Z,C,V}
    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_C = 1;
    localparam int CCR_V = 0;

    // Branch FSM states
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FLAGS = 2'd1,
        S_EVAL       = 2'd2,
        S_FLUSH      = 2'd3
    } bc_state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: (cond, ccr) -> take.
// Kept standalone so predication logic can reuse it.
module cond_eval
    import branch_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] ccr,
    output logic       take
);

    logic s_less;

    // Decode the condition against the flag bits; undefined codes never take
    always_comb begin
        s_less = ccr[CCR_N] ^ ccr[CCR_V];
        take   = 1'b0;
        case (cond)
            BC_AL:   take = 1'b1;
            BC_EQ:   take = ccr[CCR_Z];
            BC_NE:   take = ~ccr[CCR_Z];
            BC_LT:   take = s_less;
            BC_LE:   take = ccr[CCR_Z] | s_less;
            BC_GT:   take = ~(ccr[CCR_Z] | s_less);
            BC_GE:   take = ~s_less;
            BC_CS:   take = ccr[CCR_C];
            BC_CC:   take = ~ccr[CCR_C];
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch sequencer between decode and fetch. Owns the CCR, waits for
// in-flight flag writers, evaluates one branch at a time, redirects and
// flushes the front end on taken branches, and keeps saturating counters.
//
// Handshake: a branch transfers on a rising edge where br_valid & br_ready;
// br_ready is high only in IDLE, and decode holds the branch until it
// transfers. br_done/br_taken and redirect/redirect_pc are one-cycle pulses.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int AW           = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CW           = 16
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          br_valid,
    output logic          br_ready,
    input  logic [3:0]    br_cond,
    input  logic [AW-1:0] br_target,
    input  logic          flag_pending,
    input  logic          ccr_wr_en,
    input  logic [3:0]    ccr_wr_data,
    output logic [3:0]    ccr,
    output logic          stall,
    output logic          redirect,
    output logic [AW-1:0] redirect_pc,
    output logic          flush,
    output logic          br_done,
    output logic          br_taken,
    output logic [CW-1:0] taken_cnt,
    output logic [CW-1:0] nottaken_cnt,
    output logic [1:0]    dbg_state
);

    // Flush counter starts one below the total because the EVAL edge
    // already raises flush for the first cycle.
    localparam logic [3:0]    FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    bc_state_t     state_q, state_d;
    logic [3:0]    ccr_q, ccr_d;
    logic [3:0]    cond_q, cond_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          redirect_q, redirect_d;
    logic          flush_q, flush_d;
    logic          done_q, done_d;
    logic          taken_q, taken_d;
    logic [3:0]    fcnt_q, fcnt_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [CW-1:0] ncnt_q, ncnt_d;
    logic          take;

    cond_eval u_cond_eval (
        .cond (cond_q),
        .ccr  (ccr_q),
        .take (take)
    );

    // CCR write path, independent of the branch FSM
    always_comb begin
        ccr_d = ccr_wr_en ? ccr_wr_data : ccr_q;
    end

    // Next-state and registered-output logic of the branch FSM
    always_comb begin
        state_d    = state_q;
        cond_d     = cond_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        flush_d    = 1'b0;
        done_d     = 1'b0;
        taken_d    = 1'b0;
        fcnt_d     = fcnt_q;
        tcnt_d     = tcnt_q;
        ncnt_d     = ncnt_q;
        case (state_q)
            S_IDLE: begin
                if (br_valid) begin
                    cond_d  = br_cond;
                    pc_d    = br_target;
                    state_d = flag_pending ? S_WAIT_FLAGS : S_EVAL;
                end
            end
            S_WAIT_FLAGS: begin
                if (!flag_pending) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                done_d = 1'b1;
                if (take) begin
                    redirect_d = 1'b1;
                    flush_d    = 1'b1;
                    taken_d    = 1'b1;
                    fcnt_d     = FLUSH_LOAD;
                    if (tcnt_q != CNT_MAX) begin
                        tcnt_d = tcnt_q + CW'(1);
                    end
                    state_d = S_FLUSH;
                end else begin
                    if (ncnt_q != CNT_MAX) begin
                        ncnt_d = ncnt_q + CW'(1);
                    end
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    flush_d = 1'b1;
                    fcnt_d  = fcnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any branch in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ccr_q      <= 4'd0;
            cond_q     <= 4'd0;
            pc_q       <= '0;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
            done_q     <= 1'b0;
            taken_q    <= 1'b0;
            fcnt_q     <= 4'd0;
            tcnt_q     <= '0;
            ncnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            ccr_q      <= ccr_d;
            cond_q     <= cond_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            flush_q    <= flush_d;
            done_q     <= done_d;
            taken_q    <= taken_d;
            fcnt_q     <= fcnt_d;
            tcnt_q     <= tcnt_d;
            ncnt_q     <= ncnt_d;
        end
    end

    assign br_ready     = (state_q == S_IDLE);
    assign stall        = (state_q != S_IDLE);
    assign ccr          = ccr_q;
    assign redirect     = redirect_q;
    assign redirect_pc  = pc_q;
    assign flush        = flush_q;
    assign br_done      = done_q;
    assign br_taken     = taken_q;
    assign taken_cnt    = tcnt_q;
    assign nottaken_cnt = ncnt_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl (counters narrowed to 4 bits so
// saturation is reachable quickly).
module tb_branch_ctrl;
    import branch_ctrl_pkg::*;

    localparam int AW = 16;
    localparam int FC = 2;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          br_valid;
    logic          br_ready;
    logic [3:0]    br_cond;
    logic [AW-1:0] br_target;
    logic          flag_pending;
    logic          ccr_wr_en;
    logic [3:0]    ccr_wr_data;
    logic [3:0]    ccr;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          flush;
    logic          br_done;
    logic          br_taken;
    logic [CW-1:0] taken_cnt;
    logic [CW-1:0] nottaken_cnt;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    int exp_taken = 0;
    int exp_nt    = 0;

    branch_ctrl #(.AW(AW), .FLUSH_CYCLES(FC), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_valid     (br_valid),
        .br_ready     (br_ready),
        .br_cond      (br_cond),
        .br_target    (br_target),
        .flag_pending (flag_pending),
        .ccr_wr_en    (ccr_wr_en),
        .ccr_wr_data  (ccr_wr_data),
        .ccr          (ccr),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .flush        (flush),
        .br_done      (br_done),
        .br_taken     (br_taken),
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt),
        .dbg_state    (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic set_ccr(input logic [3:0] v);
        ccr_wr_en   = 1'b1;
        ccr_wr_data = v;
        step();
        ccr_wr_en = 1'b0;
        check("ccr_load", ccr, v);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_ready"}, br_ready, 1);
        check({tag, "_ccr"}, ccr, 0);
        check({tag, "_redir"}, redirect, 0);
        check({tag, "_pc"}, redirect_pc, 0);
        check({tag, "_flush"}, flush, 0);
        check({tag, "_done"}, br_done, 0);
        check({tag, "_taken"}, br_taken, 0);
        check({tag, "_tcnt"}, taken_cnt, 0);
        check({tag, "_ncnt"}, nottaken_cnt, 0);
        check({tag, "_state"}, dbg_state, S_IDLE);
    endtask

    // One branch from accept to return to IDLE; flag_pending is high for
    // `pend` cycles starting with the accept cycle, optional CCR write on
    // the last pending cycle.
    task automatic run_branch(input logic [3:0] cond, input logic [AW-1:0] tgt,
                              input int pend, input logic do_wr,
                              input logic [3:0] wdata, input logic exp_take);
        check("rdy_pre", br_ready, 1);
        br_valid     = 1'b1;
        br_cond      = cond;
        br_target    = tgt;
        flag_pending = (pend > 0);
        ccr_wr_en    = do_wr && (pend == 1);
        ccr_wr_data  = wdata;
        step();
        br_valid  = 1'b0;
        br_target = ~tgt;
        for (int c = 1; c <= pend + 1; c++) begin
            flag_pending = (c < pend);
            ccr_wr_en    = do_wr && (c == pend - 1);
            check("busy_stall", stall, 1);
            check("busy_redir", redirect, 0);
            check("busy_done", br_done, 0);
            step();
        end
        flag_pending = 1'b0;
        ccr_wr_en    = 1'b0;
        check("res_done", br_done, 1);
        check("res_taken", br_taken, exp_take);
        check("res_redir", redirect, exp_take);
        check("res_flush", flush, exp_take);
        if (exp_take) begin
            check("res_pc", redirect_pc, tgt);
            exp_taken = sat_inc(exp_taken);
        end else begin
            exp_nt = sat_inc(exp_nt);
        end
        check("res_tcnt", taken_cnt, exp_taken);
        check("res_ncnt", nottaken_cnt, exp_nt);
        if (exp_take) begin
            check("res_busy", br_ready, 0);
            for (int f = 1; f < FC; f++) begin
                step();
                check("fl_flush", flush, 1);
                check("fl_redir", redirect, 0);
                check("fl_done", br_done, 0);
                check("fl_ready", br_ready, 0);
            end
            step();
            check("fl_end", flush, 0);
            check("fl_ready_back", br_ready, 1);
        end else begin
            check("nt_ready", br_ready, 1);
            check("nt_stall", stall, 0);
        end
    endtask

    logic [3:0]  sweep_cond [10];
    logic [15:0] sweep_mask [10];

    initial begin
        // taken masks indexed by ccr value {N,Z,C,V}
        sweep_cond = '{BC_AL, BC_EQ, BC_NE, BC_LT, BC_LE, BC_GT, BC_GE, BC_CS, BC_CC, 4'hF};
        sweep_mask = '{16'hFFFF, 16'hF0F0, 16'h0F0F, 16'h55AA, 16'hF5FA,
                       16'h0A05, 16'hAA55, 16'hCCCC, 16'h3333, 16'h0000};

        rst_n        = 1'b0;
        br_valid     = 1'b0;
        br_cond      = 4'd0;
        br_target    = '0;
        flag_pending = 1'b0;
        ccr_wr_en    = 1'b0;
        ccr_wr_data  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst0");
        rst_n = 1'b1;
        step();

        // taken EQ, flush held two cycles
        set_ccr(4'b0100);
        run_branch(BC_EQ, 16'h0040, 0, 1'b0, 4'd0, 1'b1);
        check("eq_tcnt", taken_cnt, 1);

        // not-taken NE
        run_branch(BC_NE, 16'h0080, 0, 1'b0, 4'd0, 1'b0);
        check("ne_ncnt", nottaken_cnt, 1);

        // LT waiting on flags, write lands on last pending cycle
        set_ccr(4'b0000);
        run_branch(BC_LT, 16'h1234, 3, 1'b1, 4'b1000, 1'b1);
        check("lt_ccr", ccr, 4'b1000);

        // saturation of the taken counter
        for (int i = 0; i < 17; i++) begin
            run_branch(BC_AL, AW'(16'h2000 + i), 0, 1'b0, 4'd0, 1'b1);
        end
        check("tcnt_sat", taken_cnt, 15);

        // condition sweep over all CCR values
        for (int k = 0; k < 10; k++) begin
            for (int v = 0; v < 16; v++) begin
                set_ccr(4'(v));
                run_branch(sweep_cond[k], AW'({k[3:0], v[3:0], 8'h5A}), 0, 1'b0, 4'd0,
                           sweep_mask[k][v]);
            end
        end
        check("ncnt_sat", nottaken_cnt, 15);

        // reset while waiting for flags
        set_ccr(4'b0100);
        br_valid     = 1'b1;
        br_cond      = BC_EQ;
        br_target    = 16'h0ABC;
        flag_pending = 1'b1;
        step();
        br_valid = 1'b0;
        check("wf_state", dbg_state, S_WAIT_FLAGS);
        step();
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_wf");
        exp_taken    = 0;
        exp_nt       = 0;
        flag_pending = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wf_no_redir", redirect, 0);
            check("wf_no_done", br_done, 0);
        end
        check("wf_ccr", ccr, 0);

        // reset during flush
        set_ccr(4'b0100);
        br_valid  = 1'b1;
        br_cond   = BC_EQ;
        br_target = 16'h0DEF;
        step();
        br_valid = 1'b0;
        step();
        check("fl_pre_flush", flush, 1);
        check("fl_pre_redir", redirect, 1);
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_fl");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("fl_no_redir", redirect, 0);
            check("fl_no_flush", flush, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
